pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the stop (hold) and flush (bubble) inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves post-reset pipeline fill, data-memory wait states with timeout, control-flow redirects and load-use hazards under one fixed priority.

Parameters:
BOOT_CYCLES, 4, cycles all stages are held flushed after reset release (>=1)
WAIT_TIMEOUT, 16, max consecutive un-acked data-memory cycles before abort (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  rs1 index of the instruction in ID
id_rs2  in  5  rs2 index of the instruction in ID
id_rs1_use  in  1  ID instruction reads rs1
id_rs2_use  in  1  ID instruction reads rs2
ex_rd  in  5  destination register of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved a taken branch or jump
mem_req  in  1  MEM stage has an outstanding data-memory access
mem_ack  in  1  data memory completes the access this cycle
stop_pc  out  1  hold PC
stop_if_id  out  1  hold IF/ID
stop_id_ex  out  1  hold ID/EX
stop_ex_mem  out  1  hold EX/MEM
flush_if_id  out  1  bubble IF/ID
flush_id_ex  out  1  bubble ID/EX
flush_ex_mem  out  1  bubble EX/MEM
flush_mem_wb  out  1  bubble MEM/WB
mem_timeout  out  1  one-cycle pulse: memory access aborted
ctrl_state  out  2  current FSM state (BOOT=0, RUN=1, MEM_WAIT=2)

Behaviour:
- Reset is asynchronous and active-low. rst_n=0 forces state=BOOT, boot_cnt=BOOT_CYCLES-1, wait_cnt=0 and mem_timeout=0.
- BOOT outputs: all four flush_*=1, stop_pc=1, other stop_*=0, mem_timeout=0. Reset values of all outputs equal these BOOT outputs.
- Outputs are combinational from state, counters and inputs. State and counters update on posedge clk.
- BOOT: all inputs ignored. boot_cnt decrements each cycle. When boot_cnt==0, the next state is RUN. BOOT lasts exactly BOOT_CYCLES cycles after reset release.
- RUN/MEM_WAIT output priority, highest first:
  1. mem_stall = mem_req & ~mem_ack: stop_pc = stop_if_id = stop_id_ex = stop_ex_mem = 1; flush_mem_wb=1; other flushes 0. Redirect and load-use outputs are suppressed. EX is frozen, so ex_redirect re-presents after the stall.
  2. ex_redirect: flush_if_id=1, flush_id_ex=1; all stops 0.
  3. load_use = ex_mem_read & ex_rd!=0 & ((id_rs1_use & id_rs1==ex_rd) | (id_rs2_use & id_rs2==ex_rd)). Response: stop_pc=1, stop_if_id=1, flush_id_ex=1. Exactly one bubble per hazard, because the load leaves EX next cycle.
  4. Otherwise all stops and flushes are 0.
- RUN transitions: mem_stall -> MEM_WAIT with wait_cnt=1. Else stay in RUN.
- MEM_WAIT transitions:
  - mem_ack=1: stall outputs released this cycle (normal priority 2-4 applies); next state RUN; wait_cnt=0.
  - mem_ack=0 and wait_cnt==WAIT_TIMEOUT-1: abort cycle. Outputs are flush_ex_mem=1, flush_mem_wb=1, mem_timeout=1, all stops 0; redirect and load-use are ignored that cycle. Next state RUN, wait_cnt=0.
  - Otherwise: mem_stall outputs; wait_cnt++.
  - mem_req deasserted with no ack: treated as completion (-> RUN).
- A single-cycle access (ack in the same cycle as req) never leaves RUN.
- Total un-acked cycles before abort: exactly WAIT_TIMEOUT (1 in RUN + WAIT_TIMEOUT-1 in MEM_WAIT).
- Counter widths: clog2 of the parameter + 1. No wrap is possible within legal ranges.
- ctrl_state value 3 is unreachable and recovers to RUN.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0 and held at 0 during BOOT.
  - perf_stall_cnt increments in every RUN/MEM_WAIT cycle where stop_pc=1.
  - perf_flush_cnt increments in every cycle where ex_redirect causes flush_if_id=1.
  - Both counters wrap modulo 2^32.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Boot: release rst_n -> flush_*=1, stop_pc=1 for exactly 4 cycles, ctrl_state=0; cycle 5 ctrl_state=1 with all stops and flushes 0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_use=1 -> stop_pc=1, stop_if_id=1, flush_id_ex=1 for 1 cycle. Repeat with ex_rd=0 -> no stall.
- Redirect vs load-use in the same cycle: ex_redirect=1 plus a load-use match -> flush_if_id=1, flush_id_ex=1, stop_pc=0.
- Memory wait: mem_req=1 with mem_ack low for 3 cycles, high on cycle 4 -> all stops high for cycles 1-3 with ctrl_state 1,2,2; cycle 4 stops released; cycle 5 ctrl_state=1.
- Timeout: mem_req=1, mem_ack=0 held -> cycle 16 shows mem_timeout=1, flush_ex_mem=1, flush_mem_wb=1; cycle 17 ctrl_state=1, mem_timeout=0.
- Reset mid-wait: rst_n low during MEM_WAIT -> immediate BOOT outputs; after release, full 4-cycle BOOT. With PIPE_CTRL_PERF_EN, counters read 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath (master) and pipeline_ctrl (slave).
// Perf counter signals exist only when PIPE_CTRL_PERF_EN is defined.
interface pipeline_ctrl_if;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_rs1_use;
   logic        id_rs2_use;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic        ex_redirect;
   logic        mem_req;
   logic        mem_ack;
   logic        stop_pc;
   logic        stop_if_id;
   logic        stop_id_ex;
   logic        stop_ex_mem;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        flush_ex_mem;
   logic        flush_mem_wb;
   logic        mem_timeout;
   logic [1:0]  ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_rs1_use, id_rs2_use, ex_rd, ex_mem_read,
             ex_redirect, mem_req, mem_ack,
      input  stop_pc, stop_if_id, stop_id_ex, stop_ex_mem, flush_if_id,
             flush_id_ex, flush_ex_mem, flush_mem_wb, mem_timeout, ctrl_state,
             perf_stall_cnt, perf_flush_cnt
   );
   modport slave (
      input  id_rs1, id_rs2, id_rs1_use, id_rs2_use, ex_rd, ex_mem_read,
             ex_redirect, mem_req, mem_ack,
      output stop_pc, stop_if_id, stop_id_ex, stop_ex_mem, flush_if_id,
             flush_id_ex, flush_ex_mem, flush_mem_wb, mem_timeout, ctrl_state,
             perf_stall_cnt, perf_flush_cnt
   );
`else
   modport master (
      output id_rs1, id_rs2, id_rs1_use, id_rs2_use, ex_rd, ex_mem_read,
             ex_redirect, mem_req, mem_ack,
      input  stop_pc, stop_if_id, stop_id_ex, stop_ex_mem, flush_if_id,
             flush_id_ex, flush_ex_mem, flush_mem_wb, mem_timeout, ctrl_state
   );
   modport slave (
      input  id_rs1, id_rs2, id_rs1_use, id_rs2_use, ex_rd, ex_mem_read,
             ex_redirect, mem_req, mem_ack,
      output stop_pc, stop_if_id, stop_id_ex, stop_ex_mem, flush_if_id,
             flush_id_ex, flush_ex_mem, flush_mem_wb, mem_timeout, ctrl_state
   );
`endif
endinterface

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline hazard/sequencing controller: boot fill, memory wait with timeout, redirect, load-use.
// Stop/flush outputs are combinational from state and inputs; PIPE_CTRL_PERF_EN adds stall/flush counters.
module pipeline_ctrl #(
   parameter int BOOT_CYCLES  = 4,
   parameter int WAIT_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   pipeline_ctrl_if.slave    ctrl
);
   localparam int BW = $clog2(BOOT_CYCLES) + 1;
   localparam int WW = $clog2(WAIT_TIMEOUT) + 1;
   localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      ILLEGAL  = 2'd3
   } state_t;

   state_t        state;
   logic [BW-1:0] boot_cnt;
   logic [WW-1:0] wait_cnt;

   logic in_boot, mem_stall, abort, load_use, redirect_flush;
   logic stop_pc, stop_if_id, stop_id_ex, stop_ex_mem;
   logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, mem_timeout;

   assign in_boot   = (state == BOOT);
   assign mem_stall = ctrl.mem_req & ~ctrl.mem_ack;
   // Only reachable in MEM_WAIT: the RUN-side stall cycle always counts as wait 1.
   assign abort     = (state == MEM_WAIT) & mem_stall & (wait_cnt == WAIT_LAST);
   assign load_use  = ctrl.ex_mem_read & (ctrl.ex_rd != 5'd0) &
                      ((ctrl.id_rs1_use & (ctrl.id_rs1 == ctrl.ex_rd)) |
                       (ctrl.id_rs2_use & (ctrl.id_rs2 == ctrl.ex_rd)));
   assign redirect_flush = ~in_boot & ~mem_stall & ctrl.ex_redirect;

   always_comb begin
      stop_pc      = 1'b0;
      stop_if_id   = 1'b0;
      stop_id_ex   = 1'b0;
      stop_ex_mem  = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      flush_mem_wb = 1'b0;
      mem_timeout  = 1'b0;
      if (in_boot) begin
         stop_pc      = 1'b1;
         flush_if_id  = 1'b1;
         flush_id_ex  = 1'b1;
         flush_ex_mem = 1'b1;
         flush_mem_wb = 1'b1;
      end else if (abort) begin
         flush_ex_mem = 1'b1;
         flush_mem_wb = 1'b1;
         mem_timeout  = 1'b1;
      end else if (mem_stall) begin
         stop_pc      = 1'b1;
         stop_if_id   = 1'b1;
         stop_id_ex   = 1'b1;
         stop_ex_mem  = 1'b1;
         flush_mem_wb = 1'b1;
      end else if (ctrl.ex_redirect) begin
         flush_if_id  = 1'b1;
         flush_id_ex  = 1'b1;
      end else if (load_use) begin
         stop_pc      = 1'b1;
         stop_if_id   = 1'b1;
         flush_id_ex  = 1'b1;
      end
   end

   assign ctrl.stop_pc      = stop_pc;
   assign ctrl.stop_if_id   = stop_if_id;
   assign ctrl.stop_id_ex   = stop_id_ex;
   assign ctrl.stop_ex_mem  = stop_ex_mem;
   assign ctrl.flush_if_id  = flush_if_id;
   assign ctrl.flush_id_ex  = flush_id_ex;
   assign ctrl.flush_ex_mem = flush_ex_mem;
   assign ctrl.flush_mem_wb = flush_mem_wb;
   assign ctrl.mem_timeout  = mem_timeout;
   assign ctrl.ctrl_state   = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= BOOT;
         boot_cnt <= BOOT_LAST;
         wait_cnt <= '0;
      end else begin
         case (state)
            BOOT: begin
               if (boot_cnt == '0) state <= RUN;
               else                boot_cnt <= boot_cnt - 1'b1;
            end
            RUN: begin
               if (mem_stall) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WW'(1);
               end
            end
            MEM_WAIT: begin
               // Ack, dropped request or timeout all end the wait.
               if (!mem_stall || abort) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else if (in_boot) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (stop_pc)        perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (redirect_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end

   assign ctrl.perf_stall_cnt = perf_stall_cnt;
   assign ctrl.perf_flush_cnt = perf_flush_cnt;
`else
   logic unused_perf;
   assign unused_perf = redirect_flush;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed steps plus random traffic against a cycle-level reference model.
module tb_pipeline_ctrl;
   localparam int BOOT_CYCLES  = 4;
   localparam int WAIT_TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   // Reference model state: boot cycles left, consecutive un-acked memory cycles.
   int          boot_left = BOOT_CYCLES;
   int          streak = 0;
   logic [31:0] m_stall_cnt = '0;
   logic [31:0] m_flush_cnt = '0;

   pipeline_ctrl_if bus ();

   pipeline_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got=running want=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic redir, input logic req, input logic ack);
      bus.id_rs1      = rs1;
      bus.id_rs2      = rs2;
      bus.id_rs1_use  = u1;
      bus.id_rs2_use  = u2;
      bus.ex_rd       = rd;
      bus.ex_mem_read = mr;
      bus.ex_redirect = redir;
      bus.mem_req     = req;
      bus.mem_ack     = ack;
   endtask

   function automatic logic [10:0] observed();
      return {bus.stop_pc, bus.stop_if_id, bus.stop_id_ex, bus.stop_ex_mem,
              bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem, bus.flush_mem_wb,
              bus.mem_timeout, bus.ctrl_state};
   endfunction

   task automatic check_perf(input string tag);
`ifdef PIPE_CTRL_PERF_EN
      check({tag, "_pstall"}, bus.perf_stall_cnt, m_stall_cnt);
      check({tag, "_pflush"}, bus.perf_flush_cnt, m_flush_cnt);
`else
      if (tag.len() == 0) $display("empty tag");
`endif
   endtask

   // One clock: predict this cycle's outputs, compare, then advance the model at the edge.
   task automatic step(input string tag);
      logic [10:0] exp_v;
      logic [1:0]  st;
      logic        stall, lu, redir, booting;
      stall   = bus.mem_req & ~bus.mem_ack;
      redir   = bus.ex_redirect;
      lu      = bus.ex_mem_read && bus.ex_rd != 5'd0 &&
                ((bus.id_rs1_use && bus.id_rs1 == bus.ex_rd) ||
                 (bus.id_rs2_use && bus.id_rs2 == bus.ex_rd));
      booting = boot_left > 0;
      st      = (streak > 0) ? 2'd2 : 2'd1;
      if (booting)                                 exp_v = {4'b1000, 4'b1111, 1'b0, 2'd0};
      else if (stall && streak + 1 == WAIT_TIMEOUT) exp_v = {4'b0000, 4'b0011, 1'b1, st};
      else if (stall)                              exp_v = {4'b1111, 4'b0001, 1'b0, st};
      else if (redir)                              exp_v = {4'b0000, 4'b1100, 1'b0, st};
      else if (lu)                                 exp_v = {4'b1100, 4'b0100, 1'b0, st};
      else                                         exp_v = {4'b0000, 4'b0000, 1'b0, st};
      #1;
      check(tag, 32'(observed()), 32'(exp_v));
      check_perf(tag);
      @(posedge clk);
      if (booting) begin
         boot_left--;
      end else begin
         if (exp_v[10])      m_stall_cnt = m_stall_cnt + 32'd1;
         if (!stall && redir) m_flush_cnt = m_flush_cnt + 32'd1;
         if (stall) streak = (streak + 1 == WAIT_TIMEOUT) ? 0 : streak + 1;
         else       streak = 0;
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      boot_left   = BOOT_CYCLES;
      streak      = 0;
      m_stall_cnt = '0;
      m_flush_cnt = '0;
   endtask

   initial begin
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      check("reset", 32'(observed()), 32'({4'b1000, 4'b1111, 1'b0, 2'd0}));
      check_perf("reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Boot fill, with noise on inputs that must be ignored.
      set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < BOOT_CYCLES; i++) step("boot");
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("run_idle");

      // Load-use on rs1, then the load has left EX.
      set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lu_rs1");
      set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("lu_gone");
      set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lu_x0");
      set_in(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lu_rs2");
      set_in(5'd9, 5'd1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lu_nouse");

      // Redirect beats load-use.
      set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      step("redir_lu");

      // Three wait states then ack; stall outranks a pending redirect.
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step("mwait");
      bus.mem_ack = 1'b1;
      step("mwait_ack");
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("mwait_after");

      // Single-cycle access stays in RUN.
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      step("single_acc");

      // Timeout: abort on the WAIT_TIMEOUT-th un-acked cycle.
      set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < WAIT_TIMEOUT; i++) step("tmo");
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("tmo_after");

      // Request dropped without ack ends the wait.
      bus.mem_req = 1'b1;
      step("drop_req1");
      step("drop_req2");
      bus.mem_req = 1'b0;
      step("drop_req3");

      // Reset in the middle of a wait.
      bus.mem_req = 1'b1;
      for (int i = 0; i < 3; i++) step("pre_rst");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_mid", 32'(observed()), 32'({4'b1000, 4'b1111, 1'b0, 2'd0}));
      check_perf("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < BOOT_CYCLES; i++) step("reboot");

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 2) == 0));
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
